// File: rtl/gray_to_rgb_packer.sv
// Expands a stream of gray pixels into interleaved R,G,B bytes (R=G=B=gray)
// and writes them row-major into a byte-wide frame memory.
module gray_to_rgb_packer #(
    parameter int IMG_W  = 300,
    parameter int IMG_H  = 400,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        gray_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              eol,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EMIT_R,
        S_EMIT_G,
        S_EMIT_B,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        gray_q, gray_d;
    logic              pix_ready_q, pix_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              eol_q, eol_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic last_pix;
    logic xfer;

    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign xfer     = pix_valid && pix_ready_q;

    // Registered outputs reflect the state being entered, so each output
    // is computed here alongside the next-state decision.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        gray_d      = gray_q;
        pix_ready_d = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        eol_d       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    col_d       = '0;
                    row_d       = '0;
                    addr_d      = '0;
                    pix_ready_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (xfer) begin
                    state_d   = S_EMIT_R;
                    gray_d    = gray_in;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = gray_in;
                    addr_d    = addr_q + ADDR_W'(1);
                end else begin
                    pix_ready_d = 1'b1;
                end
            end
            S_EMIT_R: begin
                state_d   = S_EMIT_G;
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = gray_q;
                addr_d    = addr_q + ADDR_W'(1);
            end
            S_EMIT_G: begin
                state_d     = S_EMIT_B;
                wr_en_d     = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = gray_q;
                addr_d      = addr_q + ADDR_W'(1);
                eol_d       = (col_q == COL_LAST);
                pix_ready_d = !last_pix;
            end
            S_EMIT_B: begin
                if (last_pix) begin
                    state_d = S_DONE;
                end else begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    // A transfer here chains straight into the next pixel,
                    // sustaining one pixel every three cycles.
                    if (xfer) begin
                        state_d   = S_EMIT_R;
                        gray_d    = gray_in;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = gray_in;
                        addr_d    = addr_q + ADDR_W'(1);
                    end else begin
                        state_d     = S_WAIT;
                        pix_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_WAIT) || (state_d == S_EMIT_R) ||
                 (state_d == S_EMIT_G) || (state_d == S_EMIT_B);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            gray_q      <= '0;
            pix_ready_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            eol_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            gray_q      <= gray_d;
            pix_ready_q <= pix_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            eol_q       <= eol_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pix_ready = pix_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign eol       = eol_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gray_to_rgb_packer.sv
// Scoreboard bench for gray_to_rgb_packer on a small frame: the driver pushes
// the bytes each accepted pixel must produce; a monitor pops and compares.
module tb_gray_to_rgb_packer;

    localparam int W  = 5;
    localparam int H  = 3;
    localparam int AW = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    gray_in;
    logic          pix_valid;
    logic          pix_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          eol;
    logic          busy;
    logic          done;

    gray_to_rgb_packer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gray_in   (gray_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .eol       (eol),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int eol;
        int rdy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int pix_idx = 0;
    int nwr = 0;
    int neol = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel p of the frame lands at bytes 3p..3p+2; the
    // B byte of a row's last pixel carries eol and, unless it is the very
    // last pixel, the packer is ready for the next pixel during it.
    task automatic push_pixel(input logic [7:0] g);
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            x.addr = 3 * pix_idx + k;
            x.data = int'(g);
            x.eol  = (k == 2 && (pix_idx % W) == W - 1) ? 1 : 0;
            x.rdy  = (k == 2 && pix_idx != N - 1) ? 1 : 0;
            q.push_back(x);
        end
        pix_idx++;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (wr_en) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
                e = q.pop_front();
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
                chk("eol", int'(eol), e.eol);
                chk("pix_ready_emit", int'(pix_ready), e.rdy);
                chk("busy_emit", int'(busy), 1);
            end
            nwr++;
            if (eol) neol++;
            if (nwr == 1) first_cyc = cyc;
            last_cyc = cyc;
        end else begin
            chk("eol_no_write", int'(eol), 0);
            chk("pix_ready_vs_busy", int'(pix_ready), int'(busy));
        end
    end

    task automatic feed_pixel(input logic [7:0] g, input int gap);
        int t;
        if (gap > 0) begin
            pix_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        pix_valid = 1'b1;
        gray_in   = g;
        t = 0;
        while (!pix_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: pix_ready %0d, expected 1 within 50 cycles", pix_ready);
        end else begin
            push_pixel(g);
        end
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pix_idx = 0;
        nwr     = 0;
        neol    = 0;
    endtask

    task automatic wait_done();
        int t;
        pix_valid = 1'b0;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done_reached", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        chk("pix_ready_at_done", int'(pix_ready), 0);
        chk("queue_drained", q.size(), 0);
        chk("final_wr_addr", int'(wr_addr), 3 * N - 1);
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; gray_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_eol", int'(eol), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pix_ready", int'(pix_ready), 0);
        rst = 1'b0;

        // Idle: valid without start is ignored
        pix_valid = 1'b1; gray_in = 8'hAA;
        repeat (5) begin
            @(negedge clk);
            chk("idle_pix_ready", int'(pix_ready), 0);
            chk("idle_wr_en", int'(wr_en), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
        end
        pix_valid = 1'b0;

        // Stalled source with random gaps
        do_start();
        chk("start_busy", int'(busy), 1);
        for (int i = 0; i < N; i++) feed_pixel(8'($urandom), int'($urandom_range(0, 3)));
        wait_done();
        chk("gap_write_count", nwr, 3 * N);
        chk("gap_eol_count", neol, H);

        // Back-to-back frame, gray = pixel index
        do_start();
        for (int i = 0; i < N; i++) feed_pixel(8'(i), 0);
        wait_done();
        chk("b2b_write_count", nwr, 3 * N);
        chk("b2b_eol_count", neol, H);
        chk("b2b_sustained_span", last_cyc - first_cyc, 3 * N - 1);
        repeat (3) @(negedge clk);
        chk("done_held", int'(done), 1);

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        chk("rst_start_done", int'(done), 0);

        // Start while busy is ignored; then reset mid-frame at address 20
        do_start();
        for (int i = 0; i < 5; i++) feed_pixel(8'($urandom), 0);
        start = 1'b1;
        fork
            begin
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        feed_pixel(8'($urandom), 0);
        feed_pixel(8'($urandom), 0);
        pix_valid = 1'b0;
        t = 0;
        while (!(wr_en && wr_addr == AW'(20)) && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("reached_addr_20", int'(wr_addr), 20);
        #1;
        q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_wr_addr", int'(wr_addr), 0);
        chk("midrst_pix_ready", int'(pix_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_no_write", nwr, 21);

        do_start();
        for (int i = 0; i < N; i++) feed_pixel(8'($urandom), int'($urandom_range(0, 1)));
        wait_done();
        chk("restart_write_count", nwr, 3 * N);

        // Frame repeat after done
        do_start();
        chk("repeat_done_clear", int'(done), 0);
        chk("repeat_busy", int'(busy), 1);
        for (int i = 0; i < N; i++) feed_pixel(8'($urandom), int'($urandom_range(0, 2)));
        wait_done();
        chk("repeat_write_count", nwr, 3 * N);
        chk("repeat_eol_count", neol, H);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_to_rgb_packer.md
Name: gray_to_rgb_packer

Overview:
- Inverse-direction companion to the grayscale converter.
- Accepts a stream of 8-bit gray pixels over a valid/ready handshake and expands each pixel into three identical bytes (R=G=B=gray).
- Writes the bytes to a byte-wide frame memory in the same interleaved R,G,B raster layout as the RGB source frames: row-major, 3*IMG_W bytes per row.
- Produces a frame-complete indication so downstream dump or display logic knows when the buffer is valid.

Parameters:
- IMG_W, 300: pixels per row.
- IMG_H, 400: rows per frame.
- ADDR_W, 19: byte address width; must satisfy 2^ADDR_W >= 3*IMG_W*IMG_H (360000 at defaults).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE or DONE.
- gray_in  in  8  gray pixel value.
- pix_valid  in  1  gray_in holds a valid pixel.
- pix_ready  out  1  packer can accept a pixel this cycle.
- wr_en  out  1  byte write strobe.
- wr_addr  out  ADDR_W  byte address of the write.
- wr_data  out  8  byte written.
- eol  out  1  one-cycle pulse coincident with the B-byte write of the last pixel of each row.
- busy  out  1  frame in progress.
- done  out  1  frame complete; held until next start or rst.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous, active-high (rst).
- Reset values: state=IDLE. pix_ready, wr_en, eol, busy and done are 0. wr_addr, wr_data and all counters are 0.
- All outputs are registered.
- States: IDLE, WAIT, EMIT_R, EMIT_G, EMIT_B, DONE.
- IDLE or DONE + start:
  - go to WAIT; clear done; set busy=1;
  - clear col (0..IMG_W-1), row (0..IMG_H-1) and byte address counter.
- Handshake: a transfer occurs when pix_valid & pix_ready.
  - pix_valid may stay high across cycles.
  - gray_in must be stable while pix_valid=1 and pix_ready=0.
- pix_ready is 1 in:
  - WAIT;
  - EMIT_B, unless the pixel being emitted is the last of the frame (col=IMG_W-1 and row=IMG_H-1).
- On transfer, gray_in is latched, and the next three cycles are EMIT_R, EMIT_G, EMIT_B.
  - Each of these cycles has wr_en=1, wr_data=latched gray, and wr_addr = a, a+1, a+2, where a = 3*(row*IMG_W+col).
  - The address is generated by an incrementing counter, not a multiplier.
- Latency: transfer on cycle n gives writes on cycles n+1, n+2, n+3.
- EMIT_B transitions:
  - transfer in EMIT_B: next state is EMIT_R of the new pixel (3 cycles/pixel sustained);
  - no transfer: go to WAIT with wr_en=0;
  - last pixel of frame: go to DONE.
- col/row advance after each EMIT_B:
  - col wraps to 0 at IMG_W-1 and row increments;
  - eol=1 on the EMIT_B of col=IMG_W-1.
- DONE: busy=0, done=1, pix_ready=0, wr_en=0. The final wr_addr observed was 3*IMG_W*IMG_H-1.
- start while busy=1 is ignored; no restart and no counter clear.
- pix_valid in IDLE or DONE is ignored, since pix_ready=0. No byte is written.
- rst mid-frame: on the next edge all state returns to reset values. A pending EMIT sequence is abandoned with no further wr_en.
- rst and start asserted together: rst wins.
- wr_en is never asserted outside EMIT_R/G/B. Exactly 3*IMG_W*IMG_H writes occur per frame; the address never wraps.

Test Plan:
1. Reset then idle: hold rst 3 cycles, then pulse pix_valid=1 without start -> pix_ready=0, wr_en=0, busy=0, done=0 throughout.
2. Single pixel with IMG_W=2, IMG_H=1: start; present gray_in=8'h5A with valid at cycle n.
   - Required: writes (0,5A), (1,5A), (2,5A) on n+1..n+3.
   - Next pixel 8'hC3 gives writes (3..5, C3), eol on the write to address 5, then done=1 and busy=0.
3. Back-to-back full frame at defaults: pix_valid held 1, gray = pixel index mod 256.
   - Required: 360000 writes, one pixel every 3 cycles.
   - Byte k data = (k/3) mod 256.
   - eol pulses 400 times, at addresses 899, 1799, ...
   - done asserts after the write to address 359999.
4. Stalled source with IMG_W=3, IMG_H=2: random pix_valid gaps.
   - Required: no wr_en during gaps.
   - Addresses 0..17 contiguous and in order; data matches the accepted pixels.
   - pix_ready=0 during EMIT_R/EMIT_G.
5. Start during busy and reset mid-frame: pulse start after 5 pixels -> counters unaffected. Then assert rst at address 20 -> next cycle wr_en=0, busy=0, wr_addr=0. A new start restarts at address 0.
6. Frame repeat: after done, pulse start -> done clears next cycle and the second frame begins again at address 0.
